pdm_record_ctrl: RTL

Session controller for the PDM microphone capture path. On a start request it enables the microphone front end and discards a programmable number of settling amplitude windows. It then streams the next amplitude results into a sample RAM through a simple write port, and reports completion, sample count and peak level. It sits between the user start/stop controls, the PDM amplitude front end and the record buffer RAM.

---
 rtl/pdm_record_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pdm_record_ctrl.sv
// pdm_record_ctrl: PDM capture session controller (settle, capture to RAM, report count/peak)
// Ports: clk/rst_n (async active-low); start/stop session controls; mic_enable gates the
// front end; amplitude/amplitude_valid in; mem_we/mem_addr/mem_wdata RAM write port;
// busy, done pulse, sample_count, peak status. Define PDM_RECORD_LOOP_EN for circular
// capture with an extra wrapped output.
module pdm_record_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AMP_BITS = 7,
  parameter int SETTLE_SAMPLES = 4,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  output logic                 mic_enable,
  input  logic [AMP_BITS-1:0]  amplitude,
  input  logic                 amplitude_valid,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [AMP_BITS-1:0]  mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   sample_count,
  output logic [AMP_BITS-1:0]  peak
`ifdef PDM_RECORD_LOOP_EN
  , output logic               wrapped
`endif
);
  localparam int SW = $clog2(SETTLE_SAMPLES + 1) + 1;
  localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FINISH} state_t;
  state_t state, state_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [ADDR_BITS-1:0] ptr, ptr_n, addr_n;
  logic [AMP_BITS-1:0] wdata_n, peak_n;
  logic [ADDR_BITS:0] cnt_n;
  logic mic_n, busy_n, done_n, wr, last;
`ifdef PDM_RECORD_LOOP_EN
  logic wrap_n;
`endif
  assign wr = state == CAPTURE && amplitude_valid;
  assign last = ptr == ADDR_BITS'(DEPTH - 1);
  always_comb begin
    state_n = state;
    scnt_n = scnt;
    ptr_n = ptr;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    peak_n = peak;
    cnt_n = sample_count;
    mic_n = mic_enable;
    busy_n = busy;
    done_n = 1'b0;
`ifdef PDM_RECORD_LOOP_EN
    wrap_n = wrapped | (wr && last);
`endif
    if (wr) begin
      addr_n = ptr;
      wdata_n = amplitude;
      ptr_n = ptr + 1'b1;
      cnt_n = sample_count == FULL ? sample_count : sample_count + 1'b1;
      peak_n = amplitude > peak ? amplitude : peak;
    end
    case (state)
      IDLE: if (start && !stop) begin
        state_n = SETTLE_SAMPLES == 0 ? CAPTURE : SETTLE;
        {mic_n, busy_n} = 2'b11;
        scnt_n = '0;
        ptr_n = '0;
        cnt_n = '0;
        peak_n = '0;
`ifdef PDM_RECORD_LOOP_EN
        wrap_n = 1'b0;
`endif
      end
      SETTLE: begin
        scnt_n = amplitude_valid ? scnt + 1'b1 : scnt;
        state_n = stop ? FINISH : scnt_n == SW'(SETTLE_SAMPLES) ? CAPTURE : SETTLE;
      end
`ifdef PDM_RECORD_LOOP_EN
      CAPTURE: state_n = stop ? FINISH : CAPTURE;
`else
      CAPTURE: state_n = stop || (wr && last) ? FINISH : CAPTURE;
`endif
      default: state_n = IDLE;
    endcase
    // entering FINISH: front end off and the single done pulse, all registered together
    if (state_n == FINISH) {mic_n, busy_n, done_n} = 3'b001;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt <= '0;
      ptr <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      peak <= '0;
      sample_count <= '0;
      mic_enable <= 1'b0;
      busy <= 1'b0;
      mem_we <= 1'b0;
      done <= 1'b0;
`ifdef PDM_RECORD_LOOP_EN
      wrapped <= 1'b0;
`endif
    end else begin
      state <= state_n;
      scnt <= scnt_n;
      ptr <= ptr_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      peak <= peak_n;
      sample_count <= cnt_n;
      mic_enable <= mic_n;
      busy <= busy_n;
      mem_we <= wr;
      done <= done_n;
`ifdef PDM_RECORD_LOOP_EN
      wrapped <= wrap_n;
`endif
    end
  end
endmodule
